// File: rtl/jtframe_dwnld_pack.sv
// Packs the ioctl download byte stream into 16-bit SDRAM words, selects the bank
// from the region start addresses, buffers words in a small FIFO and drives prog_*.
module jtframe_dwnld_pack #(
  parameter int          SDRAMW    = 22,
  parameter logic [25:0] BA1_START = 26'h0400000,
  parameter logic [25:0] BA2_START = 26'h0800000,
  parameter logic [25:0] BA3_START = 26'h0C00000,
  parameter int          FIFO_AW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [25:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_ack,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  localparam int EW    = SDRAMW + 20;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;

  logic              wr_r, dl_r, dl_rr;
  logic [25:0]       addr_r;
  logic [7:0]        dout_r;
  logic [25:0]       offset;
  logic [1:0]        cur_ba;
  logic [SDRAMW-1:0] cur_waddr;
  logic              unused_offset;

  logic              held_valid;
  logic [7:0]        held_byte;
  logic [25:0]       held_addr;
  logic [SDRAMW-1:0] held_waddr;
  logic [1:0]        held_ba;
  logic              flush_pend, fall;

  logic              push_req, flush_req, hold_new, clear_held;
  logic              push_ok, accept, pop, load;
  logic [EW-1:0]     push_word;

  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty;

  // ioctl inputs are registered first; downloading goes through two stages so
  // its falling edge lines up with the last registered byte strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_r   <= 1'b0;
      addr_r <= '0;
      dout_r <= '0;
      dl_r   <= 1'b0;
      dl_rr  <= 1'b0;
    end else begin
      wr_r   <= ioctl_wr;
      addr_r <= ioctl_addr;
      dout_r <= ioctl_dout;
      dl_r   <= downloading;
      dl_rr  <= dl_r;
    end
  end

  assign fall = dl_rr & ~dl_r;

  always_comb begin
    if (addr_r >= BA3_START) begin
      cur_ba = 2'd3;
      offset = addr_r - BA3_START;
    end else if (addr_r >= BA2_START) begin
      cur_ba = 2'd2;
      offset = addr_r - BA2_START;
    end else if (addr_r >= BA1_START) begin
      cur_ba = 2'd1;
      offset = addr_r - BA1_START;
    end else begin
      cur_ba = 2'd0;
      offset = addr_r;
    end
    cur_waddr = offset[SDRAMW:1];
  end

  assign unused_offset = ^offset;

  // At most one FIFO push per cycle; a registered byte strobe wins over a flush
  always_comb begin
    push_req   = 1'b0;
    flush_req  = 1'b0;
    hold_new   = 1'b0;
    clear_held = 1'b0;
    push_word  = '0;
    if (wr_r) begin
      if (!addr_r[0]) begin
        hold_new = 1'b1;
        if (held_valid) begin
          push_req  = 1'b1;
          push_word = {held_waddr, held_ba, 8'h00, held_byte, 2'b10};
        end
      end else if (held_valid && addr_r == held_addr + 26'd1) begin
        push_req   = 1'b1;
        clear_held = 1'b1;
        push_word  = {cur_waddr, cur_ba, dout_r, held_byte, 2'b00};
      end else begin
        push_req  = 1'b1;
        push_word = {cur_waddr, cur_ba, dout_r, 8'h00, 2'b01};
      end
    end else if ((fall || flush_pend) && held_valid) begin
      push_req   = 1'b1;
      flush_req  = 1'b1;
      clear_held = 1'b1;
      push_word  = {held_waddr, held_ba, 8'h00, held_byte, 2'b10};
    end
  end

  assign full    = count[FIFO_AW];
  assign empty   = (count == '0);
  assign push_ok = push_req & ~full;
  assign accept  = ~push_req | ~full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      held_byte  <= '0;
      held_addr  <= '0;
      held_waddr <= '0;
      held_ba    <= '0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        if (hold_new) begin
          held_valid <= 1'b1;
          held_byte  <= dout_r;
          held_addr  <= addr_r;
          held_waddr <= cur_waddr;
          held_ba    <= cur_ba;
        end else if (clear_held) begin
          held_valid <= 1'b0;
        end
      end
      // a full FIFO only loses data bytes; a pending flush simply retries
      if (push_req && full && !flush_req) overflow <= 1'b1;
      if (fall || flush_pend) flush_pend <= wr_r || (held_valid && !(flush_req && !full));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The FIFO head is only popped once the controller acknowledges it
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        load      = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (prog_ack) begin
        pop       = 1'b1;
        state_nxt = prog_rdy ? IDLE : WAIT;
      end
      WAIT: if (prog_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_ba   <= '0;
    end else if (load) begin
      prog_we <= 1'b1;
      {prog_addr, prog_ba, prog_data, prog_mask} <= mem[rd_ptr];
    end else if (pop) begin
      prog_we <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dwnld_busy <= 1'b0;
    else        dwnld_busy <= downloading | wr_r | held_valid | ~empty | (state != IDLE);
  end

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Directed bench for jtframe_dwnld_pack: bank-select vector table plus
// hand-written handshake, overflow, flush and reset sequences.
module tb_jtframe_dwnld_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [25:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_ack;
  logic        prog_rdy;
  logic        dwnld_busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [25:0] addr;
    logic [7:0]  dout;
    logic [1:0]  ba;
    logic [21:0] waddr;
    logic [15:0] data;
    logic [1:0]  mask;
  } vec_t;

  vec_t vecs[9];

  jtframe_dwnld_pack dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_ba(prog_ba), .prog_we(prog_we), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
    .dwnld_busy(dwnld_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // advance one clock; everything is driven and sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [25:0] addr, input logic [7:0] dout);
    ioctl_addr = addr;
    ioctl_dout = dout;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic waitWe(input string name);
    int waited = 0;
    while (prog_we !== 1'b1 && waited < 60) begin
      tick();
      waited++;
    end
    checkOutput({name, ".we"}, {31'd0, prog_we}, 32'd1);
  endtask

  // waits for a request, checks it, holds ack off for ack_delay cycles, then acks
  task automatic expectWrite(input string name, input logic [1:0] eba, input logic [21:0] eaddr,
                             input logic [15:0] edata, input logic [1:0] emask,
                             input int ack_delay, input bit same_rdy);
    bit stable = 1'b1;
    waitWe(name);
    if (prog_we === 1'b1) begin
      checkOutput({name, ".ba"},   {30'd0, prog_ba},   {30'd0, eba});
      checkOutput({name, ".addr"}, {10'd0, prog_addr}, {10'd0, eaddr});
      checkOutput({name, ".data"}, {16'd0, prog_data}, {16'd0, edata});
      checkOutput({name, ".mask"}, {30'd0, prog_mask}, {30'd0, emask});
      for (int i = 0; i < ack_delay; i++) begin
        tick();
        if (prog_we !== 1'b1 || prog_ba !== eba || prog_addr !== eaddr ||
            prog_data !== edata || prog_mask !== emask) stable = 1'b0;
      end
      checkOutput({name, ".stable"}, {31'd0, stable}, 32'd1);
      prog_ack = 1'b1;
      prog_rdy = same_rdy;
      tick();
      prog_ack = 1'b0;
      prog_rdy = 1'b0;
      checkOutput({name, ".we_drop"}, {31'd0, prog_we}, 32'd0);
      if (!same_rdy) begin
        prog_rdy = 1'b1;
        tick();
        prog_rdy = 1'b0;
      end
    end
  endtask

  task automatic expectNoWrite(input string name, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (prog_we !== 1'b0) seen = 1'b1;
    end
    checkOutput({name, ".no_we"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    bit stable;

    vecs[0] = '{26'h0000002, 8'h12, 2'd0, 22'h000001, 16'h0012, 2'b10};
    vecs[1] = '{26'h03FFFFF, 8'h34, 2'd0, 22'h1FFFFF, 16'h3400, 2'b01};
    vecs[2] = '{26'h0400000, 8'h56, 2'd1, 22'h000000, 16'h0056, 2'b10};
    vecs[3] = '{26'h0400004, 8'hAA, 2'd1, 22'h000002, 16'h00AA, 2'b10};
    vecs[4] = '{26'h07FFFFE, 8'h78, 2'd1, 22'h1FFFFF, 16'h0078, 2'b10};
    vecs[5] = '{26'h0800001, 8'h9A, 2'd2, 22'h000000, 16'h9A00, 2'b01};
    vecs[6] = '{26'h0C00000, 8'hBC, 2'd3, 22'h000000, 16'h00BC, 2'b10};
    vecs[7] = '{26'h3FFFFFF, 8'hDE, 2'd3, 22'h1FFFFF, 16'hDE00, 2'b01};
    vecs[8] = '{26'h1000004, 8'hF0, 2'd3, 22'h200002, 16'h00F0, 2'b10};

    rst_n = 1'b0;
    downloading = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ioctl_wr = 1'b0;
    prog_ack = 1'b0;
    prog_rdy = 1'b0;
    tick(); tick(); tick();
    checkOutput("rst.we",   {31'd0, prog_we},    32'd0);
    checkOutput("rst.mask", {30'd0, prog_mask},  32'd3);
    checkOutput("rst.addr", {10'd0, prog_addr},  32'd0);
    checkOutput("rst.busy", {31'd0, dwnld_busy}, 32'd0);
    checkOutput("rst.ovf",  {31'd0, overflow},   32'd0);
    rst_n = 1'b1;
    tick();

    // single bytes across the bank boundaries; odd bytes also check push latency
    for (int i = 0; i < 9; i++) begin
      downloading = 1'b1;
      tick();
      applyStimulus(vecs[i].addr, vecs[i].dout);
      if (vecs[i].addr[0]) begin
        tick();
        checkOutput($sformatf("vec%0d.lat1", i), {31'd0, prog_we}, 32'd0);
        tick();
        checkOutput($sformatf("vec%0d.lat2", i), {31'd0, prog_we}, 32'd1);
      end
      downloading = 1'b0;
      expectWrite($sformatf("vec%0d", i), vecs[i].ba, vecs[i].waddr, vecs[i].data,
                  vecs[i].mask, 2, 1'b0);
      expectNoWrite($sformatf("vec%0d", i), 4);
      checkOutput($sformatf("vec%0d.busy", i), {31'd0, dwnld_busy}, 32'd0);
    end

    // sequential bytes pair into full words; busy falls one cycle after last rdy
    downloading = 1'b1;
    applyStimulus(26'h0, 8'h11);
    applyStimulus(26'h1, 8'h22);
    applyStimulus(26'h2, 8'h33);
    applyStimulus(26'h3, 8'h44);
    downloading = 1'b0;
    expectWrite("seq.w0", 2'd0, 22'h0, 16'h2211, 2'b00, 3, 1'b0);
    expectWrite("seq.w1", 2'd0, 22'h1, 16'h4433, 2'b00, 3, 1'b0);
    checkOutput("seq.busy_hold", {31'd0, dwnld_busy}, 32'd1);
    tick();
    checkOutput("seq.busy_fall", {31'd0, dwnld_busy}, 32'd0);

    // unmatched odd byte, held byte displaced by a new even byte, final flush
    downloading = 1'b1;
    applyStimulus(26'h0C00001, 8'h5A);
    applyStimulus(26'h0800002, 8'h77);
    applyStimulus(26'h0800006, 8'h01);
    downloading = 1'b0;
    expectWrite("mix.w0", 2'd3, 22'h0, 16'h5A00, 2'b01, 1, 1'b0);
    expectWrite("mix.w1", 2'd2, 22'h1, 16'h0077, 2'b10, 1, 1'b0);
    expectWrite("mix.w2", 2'd2, 22'h3, 16'h0001, 2'b10, 1, 1'b0);
    expectNoWrite("mix", 6);

    // ack and rdy on the same edge return straight to IDLE
    downloading = 1'b1;
    applyStimulus(26'h20, 8'hC1);
    applyStimulus(26'h21, 8'hC2);
    applyStimulus(26'h22, 8'hC3);
    applyStimulus(26'h23, 8'hC4);
    downloading = 1'b0;
    waitWe("same");
    tick(); tick();
    checkOutput("same.data0", {16'd0, prog_data}, 32'h0000C2C1);
    prog_ack = 1'b1;
    prog_rdy = 1'b1;
    tick();
    prog_ack = 1'b0;
    prog_rdy = 1'b0;
    checkOutput("same.we_low", {31'd0, prog_we}, 32'd0);
    tick();
    checkOutput("same.we_high", {31'd0, prog_we}, 32'd1);
    checkOutput("same.addr1", {10'd0, prog_addr}, 32'h11);
    expectWrite("same.w1", 2'd0, 22'h11, 16'hC4C3, 2'b00, 1, 1'b0);
    expectNoWrite("same", 6);

    // stream 20 bytes with ack held low: 4 words fit, byte 0x108 stays held
    downloading = 1'b1;
    seen = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        ioctl_addr = 26'h100 + 26'(i);
        ioctl_dout = 8'h10 + 8'(i);
        ioctl_wr   = 1'b1;
      end else begin
        ioctl_wr   = 1'b0;
      end
      tick();
      if (prog_we === 1'b1) seen = 1'b1;
      if (seen && (prog_we !== 1'b1 || prog_addr !== 22'h80 || prog_ba !== 2'd0 ||
                   prog_data !== 16'h1110 || prog_mask !== 2'b00)) stable = 1'b0;
    end
    ioctl_wr = 1'b0;
    checkOutput("ovf.req_stable", {31'd0, seen & stable}, 32'd1);
    checkOutput("ovf.flag", {31'd0, overflow}, 32'd1);
    downloading = 1'b0;
    expectWrite("ovf.w0", 2'd0, 22'h80, 16'h1110, 2'b00, 1, 1'b0);
    expectWrite("ovf.w1", 2'd0, 22'h81, 16'h1312, 2'b00, 1, 1'b0);
    expectWrite("ovf.w2", 2'd0, 22'h82, 16'h1514, 2'b00, 1, 1'b0);
    expectWrite("ovf.w3", 2'd0, 22'h83, 16'h1716, 2'b00, 1, 1'b0);
    expectWrite("ovf.flush", 2'd0, 22'h84, 16'h0018, 2'b10, 1, 1'b0);
    expectNoWrite("ovf", 8);
    checkOutput("ovf.sticky", {31'd0, overflow}, 32'd1);

    // reset during an active request, with a byte held and a word queued
    downloading = 1'b1;
    applyStimulus(26'h0, 8'hA0);
    applyStimulus(26'h1, 8'hA1);
    applyStimulus(26'h2, 8'hA2);
    waitWe("rstreq");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rstreq.we",   {31'd0, prog_we},    32'd0);
    checkOutput("rstreq.mask", {30'd0, prog_mask},  32'd3);
    checkOutput("rstreq.addr", {10'd0, prog_addr},  32'd0);
    checkOutput("rstreq.data", {16'd0, prog_data},  32'd0);
    checkOutput("rstreq.ba",   {30'd0, prog_ba},    32'd0);
    checkOutput("rstreq.busy", {31'd0, dwnld_busy}, 32'd0);
    checkOutput("rstreq.ovf",  {31'd0, overflow},   32'd0);
    applyStimulus(26'h10, 8'h21);
    applyStimulus(26'h11, 8'h43);
    downloading = 1'b0;
    expectWrite("post", 2'd0, 22'h8, 16'h4321, 2'b00, 1, 1'b0);
    expectNoWrite("post", 20);
    checkOutput("post.busy", {31'd0, dwnld_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtframe_dwnld_pack.md
Name: jtframe_dwnld_pack

Overview:
- Sits between the MiST/SPI ioctl byte stream and the SDRAM controller's ROM-load port (prog_*).
- Pairs consecutive download bytes into 16-bit words and selects the SDRAM bank from configurable region start addresses.
- Buffers words in a small FIFO and drives the prog_we/prog_ack/prog_rdy handshake.
- Holds dwnld_busy high until every byte has been committed to SDRAM.

Parameters:
- SDRAMW, 22, width of the word address per bank (22 = 32 MB, 23 = 64 MB large SDRAM)
- BA1_START, 26'h0400000, byte address where bank 1 begins
- BA2_START, 26'h0800000, byte address where bank 2 begins
- BA3_START, 26'h0C00000, byte address where bank 3 begins
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries

Ports:
- clk  in  1  ROM/SDRAM clock
- rst_n  in  1  reset, synchronous, active-low
- downloading  in  1  high while the ioctl transfer is active
- ioctl_addr  in  26  byte address of ioctl_dout
- ioctl_dout  in  8  download byte
- ioctl_wr  in  1  single-cycle byte strobe
- prog_addr  out  SDRAMW  word address within the selected bank
- prog_data  out  16  write data; low byte = even address
- prog_mask  out  2  active-low byte enables {high, low}; 00 = both bytes written
- prog_ba  out  2  SDRAM bank
- prog_we  out  1  write request
- prog_ack  in  1  controller accepted the request
- prog_rdy  in  1  controller finished the write
- dwnld_busy  out  1  download or pending writes in progress
- overflow  out  1  sticky flag: a byte was lost because the FIFO was full

Behaviour:
- Reset (rst_n low on a clk edge): prog_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prog_ba=0, dwnld_busy=0, overflow=0. FIFO is emptied, the held byte is cleared, FSM goes to IDLE. Reset mid-transfer abandons the pending request and drops prog_we on the next edge.
- Bank select, evaluated on the byte address:
  - A >= BA3_START -> ba=3, offset = A - BA3_START
  - else A >= BA2_START -> ba=2, offset = A - BA2_START
  - else A >= BA1_START -> ba=1, offset = A - BA1_START
  - else ba=0, offset = A
  - Word address = offset[SDRAMW:1]; higher bits are truncated.
- Packer, acting on each ioctl_wr:
  - Even address with no held byte: store the byte as held (low byte).
  - Odd address equal to held address + 1: push {word addr, ba, {byte, held}, mask 00}; clear held.
  - Odd address without a matching held byte: push {byte, 8'h00} with mask 01 (low byte masked).
  - Even address while a byte is held: push the old held byte with mask 10 (high byte masked), then hold the new byte. This costs one push.
  - A cycle that needs a push while the FIFO is full drops the byte and sets overflow; the held byte stays unchanged.
- Flush: on the falling edge of downloading (registered), a held byte is pushed with mask 10. If the FIFO is full, the flush retries every cycle until it succeeds.
- Issue FSM:
  - IDLE: when the FIFO is not empty, load prog_addr/data/mask/ba from the FIFO head, set prog_we=1, go to REQ.
  - REQ: prog_we and all prog_* outputs stay stable until prog_ack=1. On that edge: prog_we=0, pop the head, go to WAIT.
  - WAIT: on prog_rdy=1 go to IDLE. A prog_rdy that coincides with prog_ack in REQ is accepted, so the FSM goes straight to IDLE.
  - prog_we is low for at least one cycle between requests.
- Latency: odd-byte ioctl_wr at edge N -> FIFO entry at N+1 -> prog_we high after edge N+2 (FIFO was empty, FSM in IDLE).
- Simultaneous push and pop in the same cycle are both honoured; the occupancy count is unchanged.
- dwnld_busy = downloading OR held-byte valid OR FIFO not empty OR FSM not IDLE. It falls one cycle after the last prog_rdy once downloading is low.
- overflow clears only on reset.

Test Plan:
- Sequential bytes 0x11@0, 0x22@1, 0x33@2, 0x44@3, acking each request after 3 cycles -> two writes: addr0 data 16'h2211 mask 00; addr1 data 16'h4433 mask 00; ba=0 for both; dwnld_busy falls after the 2nd prog_rdy.
- Byte 0xAA@26'h0400004, then downloading falls -> one write: ba=1, prog_addr=2, data[7:0]=0xAA, mask 10.
- Bytes at 0x0C00001 (0x5A) and 0x0800002 (0x77), then 0x0800006 (0x01) -> first write: ba=3, addr0, data 16'h5A00, mask 01. Second write: ba=2, addr1, low byte 0x77, mask 10. Final write at addr3 after download end.
- Hold prog_ack low for 20 cycles while streaming 20 consecutive bytes one per cycle -> 4 FIFO words plus 1 held byte retained, overflow=1; prog_* outputs stable throughout REQ.
- prog_ack and prog_rdy asserted on the same edge -> FSM returns to IDLE; next prog_we rises 2 cycles later.
- rst_n low for 1 cycle while prog_we=1 -> all outputs at reset values on the next edge; new bytes are packed normally afterwards.
